gbt_frame_switch: RTL and testbench
===================================

GBT_FRAME_SWITCH -- requirements
Module: gbt_frame_switch

Interface
REQ-001 The block SHALL have parameter NCHAN, default 4: number of user frame sources, legal range 1..8.
REQ-002 The block SHALL have parameter LOOP_DELAY, default 1: loopback latency in cycles, legal range 1..16.
REQ-003 The block SHALL have parameter ERRCNT_W, default 16: width of the error counter.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 The block SHALL have port ClkRs_ix: input, ckrs_t, carrying .clk (rising edge) then .reset (synchronous, active-high).
REQ-006 The block SHALL have port rx_frame_i: input, t_sfp_stream (84 bits), received GBT frame.
REQ-007 The block SHALL have port rx_valid_i: input, 1 bit, GBT RX ready.
REQ-008 The block SHALL have port user_frame_i: input, NCHAN x t_sfp_stream, user TX sources.
REQ-009 The block SHALL have port chan_sel_i: input, max(1,$clog2(NCHAN)) bits, user channel select.
REQ-010 The block SHALL have port mode_i: input, t_gbt_mode (2 bits), requested mode: OFF=0, LOOP=1, USER=2, COUNT=3.
REQ-011 The block SHALL have port mode_req_i: input, 1 bit, mode change request strobe.
REQ-012 The block SHALL have port mode_ack_o: output, 1 bit, one-cycle pulse when the new mode becomes active.
REQ-013 The block SHALL have port mode_o: output, t_gbt_mode, currently active mode.
REQ-014 The block SHALL have port tx_frame_o: output, t_sfp_stream, frame to the GBT TX.
REQ-015 The block SHALL have port user_frame_o: output, t_sfp_stream, rx_frame_i registered once.
REQ-016 The block SHALL have port user_valid_o: output, 1 bit, rx_valid_i registered once, forced 0 outside USER mode.
REQ-017 The block SHALL have port chk_clear_i: input, 1 bit, clears the error counter.
REQ-018 The block SHALL have port chk_locked_o: output, 1 bit, counter-pattern checker locked.
REQ-019 The block SHALL have port chk_errcnt_o: output, ERRCNT_W bits, saturating mismatch count.

Function
REQ-020 The mode FSM SHALL have states RUN and DRAIN; in RUN, mode_req_i=1 latches mode_i and chan_sel_i and moves to DRAIN.
REQ-021 DRAIN SHALL last exactly 1 cycle with tx_frame_o = all zeros, then return to RUN with the latched mode; mode_o updates and mode_ack_o pulses for 1 cycle on that transition.
REQ-022 mode_req_i in DRAIN SHALL be ignored; chan_sel_i SHALL be sampled only on an accepted request; a request for the current mode SHALL still go through DRAIN and ack.
REQ-023 OFF: tx_frame_o SHALL be all zeros.
REQ-024 LOOP: tx_frame_o SHALL equal rx_frame_i delayed exactly LOOP_DELAY cycles; the delay line SHALL run in every mode, so the first frame after entering LOOP comes from real history.
REQ-025 USER: tx_frame_o SHALL equal user_frame_i[chan] registered once; chan values >= NCHAN SHALL select channel 0.
REQ-026 COUNT: tx data_b80 SHALL be {16'hBC5A, cnt[31:0], ~cnt[31:0]} with sc and ic = 0; cnt starts at 0 on entering COUNT, increments every cycle, and wraps 0xFFFFFFFF -> 0.
REQ-027 A frame SHALL be checkable only when rx_valid_i=1, the header is 16'hBC5A, and the two 32-bit fields are complements; other frames SHALL be ignored and cause no state change.
REQ-028 Checker in UNLOCKED: each checkable frame sets expected = rcvd+1 (mod 2^32); 4 consecutive matching checkable frames move the checker to LOCKED.
REQ-029 Checker in LOCKED: a mismatch SHALL increment the error counter (saturating at all ones), resync expected = rcvd+1, and 4 consecutive mismatches move the checker to UNLOCKED; any match resets the mismatch run.
REQ-030 The checker SHALL run only in COUNT mode; leaving COUNT forces UNLOCKED and holds the error count.
REQ-031 chk_clear_i SHALL zero the error counter on the next edge; clear SHALL win over a simultaneous increment.

Reset
REQ-032 On reset, all outputs SHALL be 0, the mode SHALL be OFF, the FSM in RUN, the checker UNLOCKED, the error count 0, and the delay line zeroed; reset SHALL abort DRAIN with no ack.

Structure
REQ-033 t_sfp_stream, t_gbt_mode, and constants 16'hBC5A and 4 (lock/unlock threshold) SHALL live in MCPkg.
REQ-034 The checker SHALL be the sub-module gbt_count_checker.

Verification
REQ-035 LOOP, LOOP_DELAY=3: rx_frame_i = 0x1..0x8 on consecutive cycles -> tx_frame_o shows 0x1 exactly 3 cycles after 0x1 is applied, and the sequence follows in order.
REQ-036 mode_req_i with mode_i=USER, chan_sel_i=2 -> 1 zero frame, mode_ack_o pulses once, tx_frame_o = user_frame_i[2] one cycle later; a second request during DRAIN is ignored.
REQ-037 COUNT with tx looped to rx -> chk_locked_o=1 after 4 frames; force cnt near 0xFFFFFFFE so it wraps -> no errors.
REQ-038 Locked, then 1 corrupted cnt -> errcnt=1 and the checker stays locked; 4 consecutive corrupted frames -> chk_locked_o=0.
REQ-039 Error counter at all ones plus a further mismatch -> stays saturated; chk_clear_i asserted in the same cycle as an error -> count reads 0.
REQ-040 Reset asserted during DRAIN -> no ack, mode_o=OFF, tx_frame_o=0 on the next cycle.

Source files
------------

// File: rtl/MCPkg.sv
// Shared types and constants for the GBT frame switch.
//   ckrs_t       : clock / synchronous active-high reset bundle
//   t_sfp_stream : 84-bit GBT frame {ic[1:0], sc[1:0], data_b80[79:0]}
//   t_gbt_mode   : TX source mode (OFF, LOOP, USER, COUNT)
package MCPkg;

  typedef struct packed {
    logic clk;
    logic reset;
  } ckrs_t;

  typedef struct packed {
    logic [1:0]  ic;
    logic [1:0]  sc;
    logic [79:0] data_b80;
  } t_sfp_stream;

  typedef enum logic [1:0] {
    GBT_OFF   = 2'd0,
    GBT_LOOP  = 2'd1,
    GBT_USER  = 2'd2,
    GBT_COUNT = 2'd3
  } t_gbt_mode;

  typedef enum logic {
    SW_RUN,
    SW_DRAIN
  } t_sw_state;

  typedef enum logic {
    CHK_UNLOCKED,
    CHK_LOCKED
  } t_chk_state;

  // Header word of a counter-pattern frame.
  localparam logic [15:0] GBT_CNT_HDR = 16'hBC5A;
  // Consecutive matches to lock, and consecutive mismatches to unlock.
  localparam int CHK_THRESH = 4;

endpackage

// File: rtl/gbt_count_checker.sv
// Counter-pattern checker for received GBT frames.
//   clk, reset : clock, synchronous active-high reset
//   en         : checker runs only while high; low forces UNLOCKED
//   data       : received data_b80 {hdr[15:0], cnt[31:0], ~cnt[31:0]}
//   valid      : frame valid qualifier
//   clear      : zero the error counter (wins over an increment)
//   locked     : checker locked onto the counter sequence
//   errcnt     : saturating mismatch count while locked
module gbt_count_checker
  import MCPkg::*;
#(
  parameter int ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [79:0]         data,
  input  logic                valid,
  input  logic                clear,
  output logic                locked,
  output logic [ERRCNT_W-1:0] errcnt
);

  localparam logic [2:0] RUN_LAST = 3'(CHK_THRESH - 1);

  t_chk_state  state, state_nxt;
  logic [31:0] exp_q, exp_nxt;
  logic [2:0]  run_q, run_nxt;   // match run when unlocked, miss run when locked
  logic [31:0] rcvd;
  logic        checkable, match, err_inc;

  assign rcvd      = data[63:32];
  assign checkable = valid && (data[79:64] == GBT_CNT_HDR) && (data[31:0] == ~rcvd);
  assign match     = (rcvd == exp_q);

  always_comb begin
    state_nxt = state;
    exp_nxt   = exp_q;
    run_nxt   = run_q;
    err_inc   = 1'b0;
    if (!en) begin
      state_nxt = CHK_UNLOCKED;
      run_nxt   = '0;
    end else if (checkable) begin
      // Every checkable frame resyncs the expectation to the frame seen.
      exp_nxt = rcvd + 32'd1;
      case (state)
        CHK_UNLOCKED: begin
          if (!match) begin
            run_nxt = '0;
          end else if (run_q == RUN_LAST) begin
            state_nxt = CHK_LOCKED;
            run_nxt   = '0;
          end else begin
            run_nxt = run_q + 3'd1;
          end
        end
        CHK_LOCKED: begin
          if (match) begin
            run_nxt = '0;
          end else begin
            err_inc = 1'b1;
            if (run_q == RUN_LAST) begin
              state_nxt = CHK_UNLOCKED;
              run_nxt   = '0;
            end else begin
              run_nxt = run_q + 3'd1;
            end
          end
        end
        default: state_nxt = CHK_UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CHK_UNLOCKED;
      exp_q <= '0;
      run_q <= '0;
    end else begin
      state <= state_nxt;
      exp_q <= exp_nxt;
      run_q <= run_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      errcnt <= '0;
    end else if (err_inc && (errcnt != {ERRCNT_W{1'b1}})) begin
      errcnt <= errcnt + ERRCNT_W'(1);
    end
  end

  assign locked = (state == CHK_LOCKED);

endmodule

// File: rtl/gbt_frame_switch.sv
// GBT TX frame source switch with loopback, user channels and a counter
// pattern generator/checker. Mode changes pass through a one-cycle DRAIN
// that sends a zero frame before the new source takes over.
//   ClkRs_ix     : {clk, reset} bundle, synchronous active-high reset
//   rx_frame_i   : received GBT frame, rx_valid_i its ready flag
//   user_frame_i : NCHAN user TX sources, chan_sel_i picks one
//   mode_i/mode_req_i : requested mode and request strobe
//   mode_ack_o/mode_o : activation pulse and active mode
//   tx_frame_o   : frame to the GBT TX
//   user_frame_o/user_valid_o : RX frame/valid registered once
//   chk_clear_i/chk_locked_o/chk_errcnt_o : counter-pattern checker
module gbt_frame_switch
  import MCPkg::*;
#(
  parameter int NCHAN      = 4,
  parameter int LOOP_DELAY = 1,
  parameter int ERRCNT_W   = 16,
  localparam int CHW       = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  ckrs_t                        ClkRs_ix,
  input  t_sfp_stream                  rx_frame_i,
  input  logic                         rx_valid_i,
  input  t_sfp_stream [NCHAN-1:0]      user_frame_i,
  input  logic [CHW-1:0]               chan_sel_i,
  input  t_gbt_mode                    mode_i,
  input  logic                         mode_req_i,
  output logic                         mode_ack_o,
  output t_gbt_mode                    mode_o,
  output t_sfp_stream                  tx_frame_o,
  output t_sfp_stream                  user_frame_o,
  output logic                         user_valid_o,
  input  logic                         chk_clear_i,
  output logic                         chk_locked_o,
  output logic [ERRCNT_W-1:0]          chk_errcnt_o
);

  logic clk, reset;
  assign clk   = ClkRs_ix.clk;
  assign reset = ClkRs_ix.reset;

  // ---------------- mode FSM ----------------
  t_sw_state      state, state_nxt;
  t_gbt_mode      mode_q, pend_mode;
  logic [CHW-1:0] pend_chan;
  logic           accept, drain_done;

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    drain_done = 1'b0;
    case (state)
      SW_RUN: begin
        if (mode_req_i) begin
          accept    = 1'b1;
          state_nxt = SW_DRAIN;
        end
      end
      SW_DRAIN: begin
        drain_done = 1'b1;
        state_nxt  = SW_RUN;
      end
      default: state_nxt = SW_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= SW_RUN;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q     <= GBT_OFF;
      pend_mode  <= GBT_OFF;
      pend_chan  <= '0;
      mode_ack_o <= 1'b0;
    end else begin
      mode_ack_o <= drain_done;
      if (accept) begin
        pend_mode <= mode_i;
        pend_chan <= chan_sel_i;
      end
      if (drain_done) mode_q <= pend_mode;
    end
  end

  assign mode_o = mode_q;

  // ---------------- data paths ----------------
  // Loopback delay line runs in every mode so LOOP starts from real history.
  t_sfp_stream [LOOP_DELAY-1:0] dly;

  always_ff @(posedge clk) begin
    if (reset) begin
      dly <= '0;
    end else begin
      dly[0] <= rx_frame_i;
      for (int i = 1; i < LOOP_DELAY; i++) dly[i] <= dly[i-1];
    end
  end

  // pend_chan only moves on an accepted request, so it is already the new
  // channel during DRAIN and the user register is primed when USER starts.
  t_sfp_stream user_sel, user_q;

  always_comb begin
    user_sel = user_frame_i[0];
    for (int i = 1; i < NCHAN; i++) begin
      if (pend_chan == CHW'(i)) user_sel = user_frame_i[i];
    end
  end

  t_sfp_stream rx_q;
  logic        valid_q;
  logic [31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      user_q  <= '0;
      rx_q    <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      user_q  <= user_sel;
      rx_q    <= rx_frame_i;
      valid_q <= rx_valid_i;
      // Restart on every mode activation so COUNT always begins at 0.
      cnt_q   <= drain_done ? 32'd0 : cnt_q + 32'd1;
    end
  end

  assign user_frame_o = rx_q;
  assign user_valid_o = valid_q && (mode_q == GBT_USER);

  always_comb begin
    tx_frame_o = '0;
    if (state == SW_RUN) begin
      case (mode_q)
        GBT_LOOP:  tx_frame_o = dly[LOOP_DELAY-1];
        GBT_USER:  tx_frame_o = user_q;
        GBT_COUNT: tx_frame_o.data_b80 = {GBT_CNT_HDR, cnt_q, ~cnt_q};
        default:   tx_frame_o = '0;
      endcase
    end
  end

  // ---------------- checker ----------------
  logic chk_en;
  assign chk_en = (mode_q == GBT_COUNT) && (state == SW_RUN);

  gbt_count_checker #(
    .ERRCNT_W(ERRCNT_W)
  ) u_chk (
    .clk    (clk),
    .reset  (reset),
    .en     (chk_en),
    .data   (rx_frame_i.data_b80),
    .valid  (rx_valid_i),
    .clear  (chk_clear_i),
    .locked (chk_locked_o),
    .errcnt (chk_errcnt_o)
  );

endmodule

// File: tb/tb_gbt_frame_switch.sv
module tb_gbt_frame_switch;
  import MCPkg::*;

  localparam int NCHAN      = 4;
  localparam int LOOP_DELAY = 3;
  localparam int ERRCNT_W   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ckrs_t clkrs;
  assign clkrs = '{clk: clk, reset: rst};
  always #5 clk = ~clk;

  logic [83:0]            rx_drv, rx_mux, tx, uf_out;
  logic                   loop_en, rx_valid, mode_req, ack, uv, clr, locked;
  logic [NCHAN-1:0][83:0] usr;
  logic [1:0]             chan;
  t_gbt_mode              mode_in, mode_out;
  logic [ERRCNT_W-1:0]    errcnt;

  assign rx_mux = loop_en ? tx : rx_drv;

  gbt_frame_switch #(
    .NCHAN(NCHAN), .LOOP_DELAY(LOOP_DELAY), .ERRCNT_W(ERRCNT_W)
  ) dut (
    .ClkRs_ix     (clkrs),
    .rx_frame_i   (rx_mux),
    .rx_valid_i   (rx_valid),
    .user_frame_i (usr),
    .chan_sel_i   (chan),
    .mode_i       (mode_in),
    .mode_req_i   (mode_req),
    .mode_ack_o   (ack),
    .mode_o       (mode_out),
    .tx_frame_o   (tx),
    .user_frame_o (uf_out),
    .user_valid_o (uv),
    .chk_clear_i  (clr),
    .chk_locked_o (locked),
    .chk_errcnt_o (errcnt)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [83:0] obs, input logic [83:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [83:0] cf(input logic [31:0] c);
    return {4'h0, 16'hBC5A, c, ~c};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [83:0] e;
    rx_drv = '0; loop_en = 1'b0; rx_valid = 1'b0; mode_req = 1'b0; clr = 1'b0;
    usr = '0; chan = '0; mode_in = GBT_OFF;
    tick(); tick();
    check("rst_mode", mode_out, GBT_OFF);
    check("rst_tx", tx, '0);
    check("rst_ack", ack, 1'b0);
    check("rst_uframe", uf_out, '0);
    check("rst_uvalid", uv, 1'b0);
    check("rst_locked", locked, 1'b0);
    check("rst_errcnt", errcnt, '0);
    rst = 1'b0;

    // OFF builds delay-line history; LOOP then starts from it
    rx_drv = 84'hA; rx_valid = 1'b1; tick();
    check("off_tx", tx, '0);
    rx_drv = 84'hB; mode_in = GBT_LOOP; mode_req = 1'b1; tick();
    mode_req = 1'b0;
    check("loop_drain_tx", tx, '0);
    check("loop_drain_ack", ack, 1'b0);
    check("loop_drain_mode", mode_out, GBT_OFF);
    rx_drv = '0; tick();
    check("loop_ack", ack, 1'b1);
    check("loop_mode", mode_out, GBT_LOOP);
    check("loop_hist", tx, 84'hA);
    for (int i = 1; i <= 11; i++) begin
      rx_drv = (i <= 8) ? 84'(i) : '0;
      tick();
      if (i == 1) e = 84'hB;
      else if (i >= 3 && i <= 10) e = 84'(i - 2);
      else e = '0;
      check("loop_seq", tx, e);
      if (i == 1) check("loop_ack_once", ack, 1'b0);
      if (i == 4) check("uframe_reg", uf_out, 84'h4);
      if (i == 4) check("uvalid_not_user", uv, 1'b0);
    end

    // USER, chan 2; second request in DRAIN ignored
    usr[0] = 84'h111; usr[1] = 84'h222; usr[2] = 84'hC0FFEE; usr[3] = 84'h333;
    mode_in = GBT_USER; chan = 2'd2; mode_req = 1'b1; tick();
    mode_in = GBT_COUNT; chan = 2'd3;
    check("user_drain_tx", tx, '0);
    check("user_drain_ack", ack, 1'b0);
    check("user_drain_mode", mode_out, GBT_LOOP);
    tick();
    mode_req = 1'b0;
    check("user_ack", ack, 1'b1);
    check("user_mode", mode_out, GBT_USER);
    check("user_tx", tx, 84'hC0FFEE);
    check("user_valid", uv, 1'b1);
    usr[2] = 84'hBEEF; rx_valid = 1'b0; tick();
    check("user_ack_off", ack, 1'b0);
    check("user_mode_kept", mode_out, GBT_USER);
    check("user_tx2", tx, 84'hBEEF);
    check("user_valid_low", uv, 1'b0);

    // COUNT with tx looped back to rx
    mode_in = GBT_COUNT; mode_req = 1'b1; tick();
    mode_req = 1'b0;
    check("cnt_drain_tx", tx, '0);
    tick();
    check("cnt_mode", mode_out, GBT_COUNT);
    check("cnt_tx0", tx, cf(32'd0));
    check("cnt_uvalid", uv, 1'b0);
    loop_en = 1'b1; rx_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("cnt_tx", tx, cf(32'(i)));
      check("cnt_lock", locked, (i == 4) ? 1'b1 : 1'b0);
    end
    check("cnt_err0", errcnt, 3'd0);
    loop_en = 1'b0;

    // single corruption, then resync
    rx_drv = cf(32'h4);  tick(); check("lk_match", locked, 1'b1);
    rx_drv = cf(32'h55); tick(); check("one_err_cnt", errcnt, 3'd1);
    check("one_err_lock", locked, 1'b1);
    rx_drv = cf(32'h56); tick(); check("resync_cnt", errcnt, 3'd1);

    // non-checkable frames change nothing
    rx_drv = {4'h0, 16'hBC5A, 32'h57, 32'h0};   tick();
    rx_drv = {4'h0, 16'hBC5B, 32'h57, ~32'h57}; tick();
    rx_valid = 1'b0; rx_drv = cf(32'h57); tick();
    rx_valid = 1'b1; tick();
    check("ignore_cnt", errcnt, 3'd1);
    check("ignore_lock", locked, 1'b1);

    // four consecutive mismatches unlock
    rx_drv = cf(32'h100); tick(); check("miss1", errcnt, 3'd2);
    rx_drv = cf(32'h200); tick(); check("miss2", errcnt, 3'd3);
    rx_drv = cf(32'h300); tick(); check("miss3", errcnt, 3'd4);
    check("miss3_lock", locked, 1'b1);
    rx_drv = cf(32'h400); tick(); check("miss4", errcnt, 3'd5);
    check("miss4_unlock", locked, 1'b0);

    // relock across the 32-bit wrap
    rx_drv = cf(32'hFFFF_FFFC); tick();
    rx_drv = cf(32'hFFFF_FFFD); tick();
    rx_drv = cf(32'hFFFF_FFFE); tick();
    rx_drv = cf(32'hFFFF_FFFF); tick(); check("wrap_pre", locked, 1'b0);
    rx_drv = cf(32'h0); tick(); check("wrap_lock", locked, 1'b1);
    rx_drv = cf(32'h1); tick();
    rx_drv = cf(32'h2); tick();
    check("wrap_noerr", errcnt, 3'd5);
    check("wrap_locked", locked, 1'b1);

    // saturation, then clear against a simultaneous error
    rx_drv = cf(32'h10); tick(); check("sat6", errcnt, 3'd6);
    rx_drv = cf(32'h20); tick(); check("sat7", errcnt, 3'd7);
    rx_drv = cf(32'h30); tick(); check("sat_hold", errcnt, 3'd7);
    rx_drv = cf(32'h40); clr = 1'b1; tick(); clr = 1'b0;
    check("clr_wins", errcnt, 3'd0);
    check("clr_unlock", locked, 1'b0);

    // relock, one error, then leave COUNT
    for (int i = 'h41; i <= 'h44; i++) begin
      rx_drv = cf(32'(i)); tick();
    end
    check("relock", locked, 1'b1);
    rx_drv = cf(32'h99); tick(); check("relock_err", errcnt, 3'd1);
    rx_valid = 1'b0;
    mode_in = GBT_OFF; mode_req = 1'b1; tick();
    mode_req = 1'b0;
    tick();
    check("leave_mode", mode_out, GBT_OFF);
    check("leave_ack", ack, 1'b1);
    check("leave_unlock", locked, 1'b0);
    check("leave_hold", errcnt, 3'd1);
    check("leave_tx", tx, '0);

    // reset aborts DRAIN
    mode_in = GBT_LOOP; mode_req = 1'b1; tick();
    mode_req = 1'b0;
    check("rd_drain_tx", tx, '0);
    rst = 1'b1; tick();
    check("rd_ack", ack, 1'b0);
    check("rd_mode", mode_out, GBT_OFF);
    check("rd_tx", tx, '0);
    check("rd_err", errcnt, 3'd0);
    rst = 1'b0; tick();
    check("rd_no_late_ack", ack, 1'b0);
    check("rd_mode_off", mode_out, GBT_OFF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
